// File: rtl/viterbi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : viterbi_pkg                                                |
// | Description : Shared trellis helpers for the rate-1/2 convolutional      |
// |               encoder / Viterbi decoder pair. Generator conversion and   |
// |               expected-symbol computation live here so both ends of the  |
// |               link use the same polynomial ordering.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package viterbi_pkg;

   // Default code geometry (K = 7, 8-bit metrics).
   localparam int K_DEFAULT  = 7;
   localparam int MW_DEFAULT = 8;
   localparam int M          = K_DEFAULT - 1;
   localparam int NS         = 1 << M;
   localparam logic [MW_DEFAULT-1:0] INIT_METRIC = {2'b01, {(MW_DEFAULT-2){1'b0}}};

   // An octal literal already holds the binary tap pattern: octal digit
   // bit 0 is mask bit 0. Only the low K taps are meaningful.
   function automatic logic [15:0] oct2mask(input logic [15:0] oct, input int k);
      return oct & ((16'd1 << k) - 16'd1);
   endfunction

   // Expected encoder output for input bit b leaving state s.
   // reg_vec = {b, s}: b sits on tap K-1, the oldest bit on tap 0.
   function automatic logic [1:0] exp_sym(input logic        b,
                                          input logic [15:0] s,
                                          input logic [15:0] g0_mask,
                                          input logic [15:0] g1_mask,
                                          input int          k);
      logic [15:0] reg_vec;
      reg_vec = s | ({15'd0, b} << (k - 1));
      return {^(reg_vec & g0_mask), ^(reg_vec & g1_mask)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : viterbi_acs                                                |
// | Description : Add-compare-select for one trellis state. Adds each        |
// |               predecessor metric to its branch metric and keeps the      |
// |               smaller; a tie keeps predecessor x=0.                      |
// | Ports       : pm0/pm1  predecessor metrics (x=0 / x=1)                   |
// |               bm0/bm1  branch metrics (Hamming distance 0..2)            |
// |               pm_new   surviving metric                                  |
// |               dec      1 when predecessor x=1 survives                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module viterbi_acs #(
   parameter int MW = 8
) (
   input  logic [MW-1:0] pm0,
   input  logic [MW-1:0] pm1,
   input  logic [1:0]    bm0,
   input  logic [1:0]    bm1,
   output logic [MW-1:0] pm_new,
   output logic          dec
);

   logic [MW-1:0] cand0;
   logic [MW-1:0] cand1;

   always_comb begin
      cand0  = pm0 + {{(MW-2){1'b0}}, bm0};
      cand1  = pm1 + {{(MW-2){1'b0}}, bm1};
      // Strict compare so equal candidates resolve to x=0.
      dec    = (cand1 < cand0);
      pm_new = dec ? cand1 : cand0;
   end

endmodule
`default_nettype wire

// File: rtl/viterbi_decoder_1_2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : viterbi_decoder_1_2                                        |
// | Description : Hard-decision Viterbi decoder, rate 1/2, fully parallel    |
// |               ACS over 2^(K-1) states, register-exchange survivors of    |
// |               TB_DEPTH bits, fixed decode latency.                       |
// | Ports       : clk, rst (async, active high)                              |
// |               start     re-initialise metrics, paths and counter         |
// |               in_valid  in_sym accepted this edge (no back-pressure)     |
// |               in_sym    [1]=G0 parity, [0]=G1 parity                     |
// |               out_valid one-cycle pulse qualifying out_bit               |
// |               out_bit   decoded information bit, in order                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module viterbi_decoder_1_2
   import viterbi_pkg::*;
#(
   parameter int         K        = 7,
   parameter logic [7:0] G0_OCT   = 8'o171,
   parameter logic [7:0] G1_OCT   = 8'o133,
   parameter int         TB_DEPTH = 32,
   parameter int         MW       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic [1:0] in_sym,
   output logic       out_valid,
   output logic       out_bit
);

   localparam int              MEM      = K - 1;
   localparam int              NSTATE   = 1 << MEM;
   localparam int              CW       = $clog2(TB_DEPTH + 1);
   localparam logic [MW-1:0]   PM_INIT  = {2'b01, {(MW-2){1'b0}}};
   localparam logic [15:0]     G0_MASK  = oct2mask({8'd0, G0_OCT}, K);
   localparam logic [15:0]     G1_MASK  = oct2mask({8'd0, G1_OCT}, K);
   localparam logic [CW-1:0]   CNT_FULL = CW'(TB_DEPTH);

   logic [NSTATE-1:0][MW-1:0]       pm_q, pm_d, acs_pm;
   logic [NSTATE-1:0][TB_DEPTH-1:0] path_q, path_d, path_new;
   logic [NSTATE-1:0]               dec;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            acc_q, acc_d;
   logic                            out_valid_q, out_valid_d;
   logic                            out_bit_q, out_bit_d;
   logic                            norm_en;
   logic [MEM-1:0]                  best_idx;
   logic [MW-1:0]                   best_pm;

   // One ACS per next state. Predecessors are {ns[M-2:0], x}; the input
   // bit that leads into ns is ns[M-1], so expected symbols are constants.
   generate
      for (genvar n = 0; n < NSTATE; n++) begin : g_acs
         localparam logic [MEM-1:0] NXT = MEM'(n);
         localparam logic [MEM-1:0] P0  = {NXT[MEM-2:0], 1'b0};
         localparam logic [MEM-1:0] P1  = {NXT[MEM-2:0], 1'b1};
         localparam logic [1:0]     E0  = exp_sym(NXT[MEM-1], 16'(P0), G0_MASK, G1_MASK, K);
         localparam logic [1:0]     E1  = exp_sym(NXT[MEM-1], 16'(P1), G0_MASK, G1_MASK, K);

         logic [1:0] diff0, diff1, bm0, bm1;

         assign diff0 = in_sym ^ E0;
         assign diff1 = in_sym ^ E1;
         assign bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
         assign bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};

         viterbi_acs #(.MW(MW)) u_acs (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (acs_pm[n]),
            .dec    (dec[n])
         );

         // Register exchange: inherit the winner's history, append ns[M-1].
         assign path_new[n] = dec[n] ? {path_q[P1][TB_DEPTH-2:0], NXT[MEM-1]}
                                     : {path_q[P0][TB_DEPTH-2:0], NXT[MEM-1]};
      end
   endgenerate

   // Once every metric has its MSB set, subtracting 2^(MW-1) from all of
   // them is just clearing that bit; relative ordering is unchanged.
   always_comb begin
      norm_en = 1'b1;
      for (int i = 0; i < NSTATE; i++) begin
         norm_en = norm_en & acs_pm[i][MW-1];
      end
   end

   // Lowest-index state holding the minimum metric.
   always_comb begin
      best_idx = '0;
      best_pm  = pm_q[0];
      for (int i = 1; i < NSTATE; i++) begin
         if (pm_q[i] < best_pm) begin
            best_pm  = pm_q[i];
            best_idx = MEM'(i);
         end
      end
   end

   always_comb begin
      pm_d   = pm_q;
      path_d = path_q;
      cnt_d  = cnt_q;
      acc_d  = 1'b0;
      if (start) begin
         for (int i = 0; i < NSTATE; i++) begin
            pm_d[i] = (i == 0) ? '0 : PM_INIT;
         end
         path_d = '0;
         cnt_d  = '0;
      end else if (in_valid) begin
         for (int i = 0; i < NSTATE; i++) begin
            pm_d[i] = acs_pm[i];
            if (norm_en) begin
               pm_d[i][MW-1] = 1'b0;
            end
         end
         path_d = path_new;
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + 1'b1;
         end
         acc_d = 1'b1;
      end
      // Output looks at the state left by the previous accept; it still
      // fires on a start edge because it uses the pre-restart registers.
      out_valid_d = acc_q && (cnt_q == CNT_FULL);
      out_bit_d   = out_valid_d ? path_q[best_idx][TB_DEPTH-1] : out_bit_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTATE; i++) begin
            pm_q[i] <= (i == 0) ? '0 : PM_INIT;
         end
         path_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         pm_q        <= pm_d;
         path_q      <= path_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;

endmodule
`default_nettype wire

// File: doc/viterbi_decoder_1_2.md
Name: viterbi_decoder_1_2

Overview:
Hard-decision Viterbi decoder for the rate-1/2 convolutional code produced by conv_encoder_1_2, using the same K, G0_OCT and G1_OCT conventions.
- Accepts one 2-bit symbol per clock and runs fully parallel add-compare-select over all 2^(K-1) states.
- Keeps survivors in a register-exchange memory of depth TB_DEPTH and emits decoded bits with fixed latency.
- Sits at the receive end of the link, downstream of the channel model and error injector.

Parameters:
K, 7, constraint length (3..9); M = K-1, NS = 2^M states
G0_OCT, 8'o171, octal generator for in_sym[1]; octal digit bit0 maps to mask bit 0, mask bit K-1 taps the new input bit
G1_OCT, 8'o133, octal generator for in_sym[0]
TB_DEPTH, 32, survivor length in bits (>= 2)
MW, 8, path-metric width in bits (must satisfy 2^(MW-2) > 2*M+2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  synchronous restart: re-initialise metrics, paths and counter (encoder state assumed zero)
in_valid  in  1  in_sym valid this cycle; no back-pressure, accepted whenever high
in_sym  in  2  received symbol, [1]=G0 parity, [0]=G1 parity
out_valid  out  1  one-cycle pulse, out_bit valid
out_bit  out  1  decoded information bit, in order

Behaviour:
- Trellis matches the encoder exactly:
  - reg_vec = {b, s}; expected sym = {^(reg_vec&G0_MASK), ^(reg_vec&G1_MASK)}.
  - Next state ns = {b, s[M-1:1]}.
  - Predecessors of ns: p_x = {ns[M-2:0], x} for x in {0,1}, with b = ns[M-1].
- Branch metric = Hamming distance (0..2) between in_sym and the expected symbol.
- ACS: cand_x = pm[p_x] + bm_x. Select the smaller; a tie selects x=0.
- Survivor update: path'[ns] = {path[p_sel][TB_DEPTH-2:0], ns[M-1]}.
- Normalisation: after ACS, if every new metric has its MSB set, clear the MSB of all of them in the same edge. Metrics never wrap.
- Reset / start initialisation:
  - pm[0]=0; pm[s!=0]=2^(MW-2).
  - All paths 0; symbol counter cnt=0; out_valid=0; out_bit=0.
- Accept edge: on a rising edge with in_valid=1 and start=0, update metrics and paths. cnt saturates at TB_DEPTH.
- Output stage (registered, one edge after the accept edge):
  - If the previous edge accepted a symbol and cnt >= TB_DEPTH: out_valid=1 and out_bit = path[best][TB_DEPTH-1].
  - best = lowest-index state holding the minimum metric.
  - Otherwise out_valid=0.
- Latency: for the symbol of information bit n accepted at edge t, out_valid is high after edge t+1 carrying bit n-TB_DEPTH+1. The first output appears after the TB_DEPTH-th accepted symbol.
- Gaps in in_valid: freeze all state; out_valid stays 0.
- start and in_valid in the same cycle: start wins and the symbol is dropped. An out_valid pending from the previous accept still fires. The next edge is clean.
- rst asserted mid-stream: immediate return to the reset values listed above. Nothing from before reset is ever output.
- No flush: the sender appends M zero tail bits plus TB_DEPTH-1 padding symbols to drain the last bits.

Decomposition:
- Package viterbi_pkg:
  - function oct2mask(oct, K);
  - function exp_sym(b, s, g0_mask, g1_mask) shared with conv_encoder_1_2;
  - localparams M, NS, INIT_METRIC.
- Sub-module viterbi_acs: one per next state (NS instances).
  - Inputs: two predecessor metrics, two branch metrics.
  - Outputs: new metric and decision bit; tie resolves to x=0.
- The top level holds the metric/path registers, normaliser, best-state min tree, counter and output register.

Test Plan:
- All-zero: rst, then 64 symbols 00 -> first out_valid 1 cycle after the 32nd accept; 33 outputs, all 0; pm[0] stays 0.
- Encoder loopback, K=7 (171,133), error-free:
  - Input: 100 $random bits (seed 32'hdeadbeef) + 6 zero tail + 31 pad.
  - Expect: 106 outputs match the source bits exactly, in order.
- Single-error correction: same stream with in_sym bit 1 flipped at symbols 20, 50, 80 (errors spaced > 2K) -> output identical to source.
- Gapped input: same loopback with in_valid low on every third cycle -> identical output; out_valid never high in a cycle following a non-accept cycle.
- Normalisation soak: 3000 random symbols with 1 error per 40 -> no metric wrap (assert MSB-clear events occur), outputs match the source.
- Restart/reset:
  - start pulsed with in_valid at symbol 40 -> that symbol dropped; the next TB_DEPTH-1 accepts produce no out_valid; the new stream decodes correctly.
  - rst mid-stream -> out_valid=0 immediately; then the same as above.
